// File: rtl/spi_slave_rx_if.sv
// Pin-side and register-side signals of the SPI slave receiver.
// The slave modport is the receiver's view; the master modport is the pins/register block.
interface spi_slave_rx_if #(
  parameter int DATA_W = 8
);
  logic              spe;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic              sck;
  logic              ss_n;
  logic              mosi;
  logic              rd_spdr;
  logic [DATA_W-1:0] spdr_rx;
  logic              spif;
  logic              ovr;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  spe, cpol, cpha, lsb_first, sck, ss_n, mosi, rd_spdr,
    output spdr_rx, spif, ovr, frame_err, busy
  );

  modport master (
    output spe, cpol, cpha, lsb_first, sck, ss_n, mosi, rd_spdr,
    input  spdr_rx, spif, ovr, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronises sck/ss_n/mosi, assembles frames into spdr_rx.
// Frame visible one clk after its last sample edge; no backpressure, unread frames set ovr.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  spi_slave_rx_if.slave bus
);
  localparam int            CW   = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ARMED, RECEIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sync;
  logic [SYNC_STAGES-1:0]  ss_n_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sck_d;
  logic                    sck_s;
  logic                    ss_n_s;
  logic                    mosi_s;
  logic                    mode_cpol;
  logic                    mode_cpha;
  logic                    mode_lsb;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_W-1:0]       shreg;
  logic [DATA_W-1:0]       shreg_nxt;
  logic [DATA_W-1:0]       spdr_q;
  logic                    spif_q;
  logic                    ovr_q;
  logic                    frame_err_q;
  logic                    busy_q;
  logic                    sck_chg;
  logic                    lead_edge;
  logic                    trail_edge;
  logic                    sample;

  // Identical chains keep the three pins mutually aligned after synchronisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '1;
      ss_n_sync <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], bus.ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ss_n_s     = ss_n_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sck_chg    = sck_s ^ sck_d;
  assign lead_edge  = sck_chg & (sck_s != mode_cpol);
  assign trail_edge = sck_chg & (sck_s == mode_cpol);
  assign sample     = mode_cpha ? trail_edge : lead_edge;

  always_comb begin
    shreg_nxt = {shreg[DATA_W-2:0], mosi_s};
    if (mode_lsb) begin
      shreg_nxt = {mosi_s, shreg[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_cpol   <= 1'b0;
      mode_cpha   <= 1'b0;
      mode_lsb    <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      spdr_q      <= '0;
      spif_q      <= 1'b0;
      ovr_q       <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // A completing frame below overrides this read acknowledge.
      if (bus.rd_spdr) begin
        spif_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.spe) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (!bus.spe) begin
            state <= IDLE;
          end else if (!ss_n_s) begin
            state     <= RECEIVE;
            busy_q    <= 1'b1;
            bit_cnt   <= '0;
            shreg     <= '0;
            mode_cpol <= bus.cpol;
            mode_cpha <= bus.cpha;
            mode_lsb  <= bus.lsb_first;
          end
        end
        RECEIVE: begin
          if (!bus.spe) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
          end else if (ss_n_s) begin
            state       <= ARMED;
            busy_q      <= 1'b0;
            frame_err_q <= (bit_cnt != '0);
            bit_cnt     <= '0;
            shreg       <= '0;
          end else if (sample) begin
            shreg <= shreg_nxt;
            if (bit_cnt == LAST) begin
              bit_cnt <= '0;
              if (!spif_q || bus.rd_spdr) begin
                spdr_q <= shreg_nxt;
                spif_q <= 1'b1;
                ovr_q  <= ovr_q;
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spdr_rx   = spdr_q;
  assign bus.spif      = spif_q;
  assign bus.ovr       = ovr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
endmodule
